// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader: streams a contiguous block of RAM words out on a valid/ready port.
// A 2-entry skid FIFO absorbs the RAM's one-cycle registered read latency under backpressure.
module dpram_stream_reader #(
    parameter int VECTOR_LENGTH = 512,
    parameter int WORD_WIDTH = 32,
    localparam int ADDR_WIDTH = $clog2(VECTOR_LENGTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rclke_o,
    output logic                  re_o,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    input  logic [WORD_WIDTH-1:0] rdata_i,
    output logic [WORD_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(VECTOR_LENGTH-1);
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [ADDR_WIDTH:0] left_q, len_q, beats_q;
    logic [WORD_WIDTH-1:0] fifo_q [2];
    logic [1:0] count_q;
    logic wr_q, rd_q, inflight_q, done_q, done_d;
    logic pop, push, re, kill;
    logic [2:0] occ;
    assign pop = m_valid_o & m_ready_i;
    assign kill = abort_i & (state_q != IDLE);
    assign push = inflight_q & ~kill;
    assign occ = {1'b0, count_q} + {2'b0, inflight_q};
    // Counting the pop this cycle lets a read issue into the slot being freed.
    assign re = (state_q == RUN) & (occ < 3'd2 + {2'b0, pop});
    assign re_o = re;
    assign rclke_o = re;
    assign raddr_o = raddr_q;
    assign busy_o = state_q != IDLE;
    assign done_o = done_q;
    assign m_valid_o = count_q != 2'd0;
    assign m_data_o = fifo_q[rd_q];
    assign m_last_o = m_valid_o & (beats_q == len_q - ONE);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
    always_comb begin
        state_d = state_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = (start_i && len_i != '0) ? RUN : IDLE;
                done_d = start_i && len_i == '0;
            end
            RUN: state_d = (re && left_q == ONE) ? DRAIN : RUN;
            DRAIN: begin
                state_d = (pop && m_last_o) ? IDLE : DRAIN;
                done_d = pop && m_last_o;
            end
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
            done_d = 1'b0;
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            raddr_q <= '0;
            left_q <= '0;
            len_q <= '0;
            beats_q <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            count_q <= '0;
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            inflight_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (state_q == IDLE && start_i) begin
                raddr_q <= base_addr_i;
                left_q <= len_i;
                len_q <= len_i;
                beats_q <= '0;
            end
            if (kill) begin
                inflight_q <= 1'b0;
                count_q <= '0;
                wr_q <= 1'b0;
                rd_q <= 1'b0;
            end else begin
                inflight_q <= re;
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
                if (re) begin
                    raddr_q <= (raddr_q == TOP) ? '0 : raddr_q + 1'b1;
                    left_q <= left_q - ONE;
                end
                if (push) begin
                    fifo_q[wr_q] <= rdata_i;
                    wr_q <= ~wr_q;
                end
                if (pop) begin
                    rd_q <= ~rd_q;
                    beats_q <= beats_q + ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_dpram_stream_reader.sv
// tb_dpram_stream_reader: directed checks of dpram_stream_reader against a registered-read RAM model.
module tb_dpram_stream_reader;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, m_ready = 1'b0;
    logic [8:0] base = '0, raddr;
    logic [9:0] len = '0;
    logic busy, done, rclke, re, m_valid, m_last;
    logic [31:0] rdata = '0, m_data;
    logic [31:0] ram [512];
    int n_checks = 0, n_fail = 0;
    dpram_stream_reader dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_addr_i(base), .len_i(len),
        .abort_i(abort), .busy_o(busy), .done_o(done), .rclke_o(rclke), .re_o(re),
        .raddr_o(raddr), .rdata_i(rdata), .m_data_o(m_data), .m_valid_o(m_valid),
        .m_ready_i(m_ready), .m_last_o(m_last)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (rclke && re) rdata <= ram[raddr];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_re"}, re, 0);
        check({tag, "_rclke"}, rclke, 0);
        check({tag, "_raddr"}, raddr, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_last"}, m_last, 0);
        check({tag, "_data"}, m_data, 0);
    endtask
    task automatic start_xfer(input int b, input int l);
        base = 9'(b);
        len = 10'(l);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask
    // Called just after the start edge; follows the transfer cycle by cycle.
    task automatic collect(input int b, input int l, input bit rnd, input int stop, input int lat, input bit poke);
        int idx = 0, issued = 0, cyc = 0;
        logic pv = 1'b0, pr = 1'b0, hs;
        logic [31:0] pd = '0;
        while (idx < stop && cyc < l * 8 + 20) begin
            @(negedge clk);
            hs = m_valid && m_ready;
            if (cyc == 0) check("busy_run", busy, 1);
            check("rclke_eq_re", rclke, re);
            if (re) begin
                check("raddr", raddr, (b + issued) % 512);
                issued++;
            end
            if (pv && !pr) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, pd);
            end
            if (hs) begin
                if (idx == 0 && lat >= 0) check("latency", cyc, lat);
                check("data", m_data, 32'hA500_0000 + (b + idx) % 512);
                check("last", m_last, idx == l - 1);
                idx++;
            end
            check("outstanding", (issued - idx) <= 2, 1);
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            cyc++;
            if (idx < stop) begin
                @(posedge clk);
                #1;
                start = poke && cyc == 1;
                base = 9'd100;
                len = 10'd3;
                if (rnd) m_ready = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        if (idx < stop) check("timeout", idx, stop);
        if (stop == l) begin
            @(negedge clk);
            check("done_pulse", done, 1);
            check("busy_fall", busy, 0);
            check("issued_total", issued, l);
            @(negedge clk);
            check("done_once", done, 0);
        end
    endtask
    initial begin
        for (int k = 0; k < 512; k++) ram[k] = 32'hA500_0000 + k;
        #12;
        check_idle_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        start_xfer(10, 4);
        collect(10, 4, 1'b0, 4, 2, 1'b0);
        m_ready = 1'b1;
        start_xfer(0, 16);
        collect(0, 16, 1'b1, 16, -1, 1'b0);
        m_ready = 1'b1;
        start_xfer(510, 4);
        collect(510, 4, 1'b0, 4, 2, 1'b0);
        start_xfer(5, 0);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_re", re, 0);
        @(negedge clk);
        check("zero_done_once", done, 0);
        check("zero_busy2", busy, 0);
        check("zero_re2", re, 0);
        start_xfer(0, 512);
        collect(0, 512, 1'b0, 512, 2, 1'b0);
        start_xfer(0, 8);
        collect(0, 8, 1'b0, 3, 2, 1'b0);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        check("abort_inflight_valid", m_valid, 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("abort_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_re", re, 0);
        @(negedge clk);
        check("abort_done2", done, 0);
        check("abort_valid2", m_valid, 0);
        @(posedge clk);
        #1;
        start_xfer(0, 2);
        collect(0, 2, 1'b0, 2, 2, 1'b0);
        start_xfer(20, 6);
        collect(20, 6, 1'b0, 6, 2, 1'b1);
        start_xfer(40, 8);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("held_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_xfer(10, 4);
        collect(10, 4, 1'b0, 4, 2, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dpram_stream_reader.md
# dpram_stream_reader

Read-side initiator for the fabric's dual-port RAM. On a start command it reads a contiguous block of words from the RAM read port, starting at a base address, and presents them on a valid/ready stream in address order, applying backpressure correctly across the RAM's one-cycle registered read latency. It sits between a RAM instance, which some other agent fills through the write port, and any streaming consumer, for example a USB transmit path.

## Interface

Parameters:
- VECTOR_LENGTH, 512, number of RAM words; sets address range.
- WORD_WIDTH, 32, RAM word width and stream data width.
- ADDR_WIDTH (localparam), $clog2(VECTOR_LENGTH), not overridable.

Ports:
- clk_i  in  1  sole clock; RAM read clock must be the same clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  command strobe; sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first word address; sampled with start_i.
- len_i  in  ADDR_WIDTH+1  word count, 0..VECTOR_LENGTH; sampled with start_i.
- abort_i  in  1  cancel the current transfer.
- busy_o  out  1  high from accepted start until done or abort.
- done_o  out  1  one-cycle pulse on normal completion.
- rclke_o  out  1  RAM read clock enable; identical to re_o.
- re_o  out  1  RAM read enable.
- raddr_o  out  ADDR_WIDTH  RAM read address.
- rdata_i  in  WORD_WIDTH  RAM read data; valid the cycle after re_o.
- m_data_o  out  WORD_WIDTH  stream data.
- m_valid_o  out  1  stream valid.
- m_ready_i  in  1  stream ready.
- m_last_o  out  1  marks the final word of a transfer; qualified by m_valid_o.

## Operation

- FSM states:
  - IDLE.
  - RUN: reads remain to be issued.
  - DRAIN: all reads issued; waiting for the final beat to be accepted.
- IDLE -> RUN: start_i=1 and len_i>0. Latch base_addr_i and len_i; set busy_o.
- IDLE with start_i=1 and len_i=0: no read is issued. done_o pulses the next cycle. busy_o stays 0.
- RUN -> DRAIN: the last read has been issued.
- DRAIN -> IDLE: the beat with m_last_o is accepted (m_valid_o & m_ready_i).
- start_i outside IDLE is ignored.
- Read issue:
  - Condition: re_o = RUN & (fifo_count + inflight - pop < 2), where pop = m_valid_o & m_ready_i.
  - The m_ready_i -> re_o combinational path is intentional.
- Address:
  - Each issued read increments raddr_o modulo VECTOR_LENGTH.
  - Base 510 with VECTOR_LENGTH 512 reads 510, 511, 0, 1, ...
- Return path:
  - inflight is a 1-bit register set when re_o is asserted.
  - When inflight=1, rdata_i is pushed into a 2-entry FIFO.
  - The FIFO never overflows under the issue rule.
- Stream:
  - m_data_o and m_valid_o come from the FIFO head.
  - m_last_o is high on the head entry whose index equals len-1. Count accepted beats, not issued reads.
  - Data is held stable while m_valid_o=1 and m_ready_i=0.
- Abort (abort_i=1 in RUN or DRAIN):
  - Next cycle: state IDLE, FIFO flushed, m_valid_o=0, busy_o=0, no done_o pulse.
  - A read in flight at abort time is discarded, never pushed.
  - abort_i in IDLE has no effect.
  - abort_i wins over a simultaneous final handshake: the beat counts as transferred, but no done_o pulse.
- Asynchronous reset: all state cleared immediately, including mid-transfer. Post-reset behaviour is identical to power-up.

## Timing

- Reset values: busy_o=0, done_o=0, rclke_o=0, re_o=0, raddr_o=0, m_valid_o=0, m_last_o=0, m_data_o=0. State IDLE, FIFO empty, inflight=0.
- Start accepted at clock edge E0:
  - First re_o in the cycle after E0, with raddr_o=base.
  - rdata_i valid one cycle later.
  - First m_valid_o two cycles after re_o, i.e. 3 cycles after the start cycle.
- Throughput with m_ready_i held high: one word per cycle after the initial latency.
- done_o pulses and busy_o falls in the cycle after the final handshake.
- A new start is accepted in that same cycle, since state is IDLE.

## Test plan

- Basic: RAM word k holds 0xA5000000+k; base=10, len=4; m_ready_i=1 -> m_data_o = 0xA500000A..0xA500000D on consecutive cycles. First valid 3 cycles after start; m_last_o on 0xA500000D; done_o one cycle later.
- Backpressure: len=16, random m_ready_i at 50% -> all 16 words in order, none dropped or duplicated. Data stable while stalled. re_o never leaves more than 2 words outstanding or buffered.
- Wrap: base=510, len=4 -> raddr_o sequence 510, 511, 0, 1; data matches those words.
- Zero length: start with len=0 -> no re_o, done_o pulses once, busy_o never rises. Also len=512 (full RAM) from base 0 -> 512 words, last word is index 511.
- Abort: len=8, abort_i after the 3rd accepted beat while m_ready_i=0 and a read is in flight -> m_valid_o=0 next cycle, no done_o, no stale word after a following start (base=0, len=2) returns words 0 and 1.
- Reset mid-run, and start while busy: a start pulse in RUN is ignored; rst_n_i low mid-transfer -> all outputs return to reset values immediately; a subsequent start behaves as in the Basic scenario.
